// File: rtl/muldiv_controller_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle MULT/DIV sequencer.
// The pipeline side drives requests (master); the sequencer returns status and HI/LO (slave).
interface muldiv_controller_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_MD_OP = 2
);
    logic                i_start;
    logic [NB_MD_OP-1:0] i_md_op;
    logic [NB_DATA-1:0]  i_operand_a;
    logic [NB_DATA-1:0]  i_operand_b;
    logic                i_flush;
    logic                i_mf_req;
    logic                o_busy;
    logic                o_done;
    logic                o_div_zero;
    logic                o_stall;
    logic [NB_DATA-1:0]  o_hi;
    logic [NB_DATA-1:0]  o_lo;

    modport master (
        output i_start, i_md_op, i_operand_a, i_operand_b, i_flush, i_mf_req,
        input  o_busy, o_done, o_div_zero, o_stall, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_md_op, i_operand_a, i_operand_b, i_flush, i_mf_req,
        output o_busy, o_done, o_div_zero, o_stall, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_controller.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer: shift-add multiply or restoring divide on
// magnitudes over NB_DATA cycles, sign fix-up in ADJUST, result committed to HI/LO on DONE.
module muldiv_controller #(
    parameter int NB_DATA  = 32,
    parameter int NB_CNT   = $clog2(NB_DATA) + 1,
    parameter int NB_MD_OP = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    muldiv_controller_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, ADJUST, DONE} state_t;

    state_t                 state_q;
    logic [NB_CNT-1:0]      cnt_q;
    logic [2*NB_DATA-1:0]   acc_q;
    logic [2*NB_DATA-1:0]   acc_d;
    logic [NB_DATA-1:0]     mcand_q;
    logic [NB_DATA-1:0]     hi_q, lo_q;
    logic [NB_DATA-1:0]     hi_d, lo_d;
    logic                   is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic                   busy_q, done_q, div_zero_q;

    logic                   is_div_in, signed_in, sign_a_in, sign_b_in;
    logic [NB_DATA-1:0]     abs_a_in, abs_b_in;
    logic [NB_DATA:0]       mul_sum;
    logic [NB_DATA:0]       div_trial;
    logic [2*NB_DATA-1:0]   mul_next, div_next, prod_adj;

    function automatic logic [NB_DATA-1:0] abs_val(input logic signed [NB_DATA-1:0] x,
                                                   input logic en);
        return (en && x[NB_DATA-1]) ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [NB_DATA-1:0] neg_word(input logic [NB_DATA-1:0] x);
        return ~x + 1'b1;
    endfunction

    always_comb begin
        is_div_in = bus.i_md_op[1];
        signed_in = ~bus.i_md_op[0];
        sign_a_in = signed_in & bus.i_operand_a[NB_DATA-1];
        sign_b_in = signed_in & bus.i_operand_b[NB_DATA-1];
        abs_a_in  = abs_val(bus.i_operand_a, signed_in);
        abs_b_in  = abs_val(bus.i_operand_b, signed_in);
    end

    // One iteration: multiply adds into the upper half then shifts right (carry kept in
    // mul_sum); divide shifts left and keeps the trial difference when it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} +
                    (acc_q[0] ? {1'b0, mcand_q} : {(NB_DATA+1){1'b0}});
        mul_next  = {mul_sum, acc_q[NB_DATA-1:1]};
        div_trial = acc_q[2*NB_DATA-1:NB_DATA-1] - {1'b0, mcand_q};
        div_next  = div_trial[NB_DATA] ? {acc_q[2*NB_DATA-2:0], 1'b0}
                                       : {div_trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
        acc_d     = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        prod_adj = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        hi_d     = prod_adj[2*NB_DATA-1:NB_DATA];
        lo_d     = prod_adj[NB_DATA-1:0];
        if (dz_q) begin
            hi_d = acc_q[2*NB_DATA-1:NB_DATA];
            lo_d = acc_q[NB_DATA-1:0];
        end else if (is_div_q) begin
            hi_d = neg_rem_q ? neg_word(acc_q[2*NB_DATA-1:NB_DATA]) : acc_q[2*NB_DATA-1:NB_DATA];
            lo_d = neg_res_q ? neg_word(acc_q[NB_DATA-1:0]) : acc_q[NB_DATA-1:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start && !bus.i_flush) begin
                        is_div_q  <= is_div_in;
                        neg_res_q <= sign_a_in ^ sign_b_in;
                        neg_rem_q <= sign_a_in;
                        mcand_q   <= is_div_in ? abs_b_in : abs_a_in;
                        busy_q    <= 1'b1;
                        // Divide by zero skips CALC; ADJUST passes acc through as {a, all-ones}.
                        if (is_div_in && (bus.i_operand_b == '0)) begin
                            dz_q    <= 1'b1;
                            acc_q   <= {bus.i_operand_a, {NB_DATA{1'b1}}};
                            state_q <= ADJUST;
                        end else begin
                            dz_q    <= 1'b0;
                            acc_q   <= {{NB_DATA{1'b0}}, is_div_in ? abs_a_in : abs_b_in};
                            cnt_q   <= NB_CNT'(NB_DATA);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.i_flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == NB_CNT'(1)) state_q <= ADJUST;
                    end
                end
                ADJUST: begin
                    if (bus.i_flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q       <= hi_d;
                        lo_q       <= lo_d;
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_div_zero = div_zero_q;
    assign bus.o_stall    = busy_q & bus.i_mf_req;
    assign bus.o_hi       = hi_q;
    assign bus.o_lo       = lo_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: vector table of MULT/DIV cases plus hand-written
// flush, ignored-start, stall and mid-op reset sequences.
module tb_muldiv_controller;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_controller_if #(.NB_DATA(N), .NB_MD_OP(2)) bus ();

    muldiv_controller #(.NB_DATA(N), .NB_MD_OP(2)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one op, waits (bounded) for o_done, checks latency/busy/stall window and the
    // idle cycle that follows, then returns the committed HI/LO.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, output logic [N-1:0] hi,
                          output logic [N-1:0] lo, output logic dz);
        int lat;
        int busy_cnt;
        int stall_cnt;
        int exp_lat;
        exp_lat = (op[1] && b == '0) ? 1 : N + 1;
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_md_op     = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        lat = 0; busy_cnt = 0; stall_cnt = 0;
        while (1) begin
            if (bus.o_busy) busy_cnt++;
            if (bus.o_stall) stall_cnt++;
            if (bus.o_done || lat > 100) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, busy_cnt, exp_lat + 1);
        chk({nm, "_stall_cycles"}, stall_cnt, bus.i_mf_req ? exp_lat + 1 : 0);
        hi = bus.o_hi;
        lo = bus.o_lo;
        dz = bus.o_div_zero;
        @(posedge clk); #1;
        chk({nm, "_idle_after"}, {bus.o_busy, bus.o_done, bus.o_stall}, 3'b000);
    endtask

    logic [N-1:0] hi, lo;
    logic         dz;
    int           done_seen;

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'b11, 32'd10,       32'd3,        32'd1,        32'd3,        1'b0};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{2'b00, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_md_op = 2'b00; bus.i_operand_a = '0; bus.i_operand_b = '0;
        bus.i_flush = 1'b0; bus.i_mf_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_stall}, 4'b0000);
        chk("reset_hi", bus.o_hi, 32'h0);
        chk("reset_lo", bus.o_lo, 32'h0);
        rst_n = 1'b1;

        // Back-to-back: each run_op starts in the first IDLE cycle after the previous DONE.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_divzero", i), dz, vecs[i].dz);
        end

        // Flush mid-op: a second start at cycle 5 is ignored, flush at cycle 10 aborts.
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_md_op = 2'b01; bus.i_operand_a = 32'd3; bus.i_operand_b = 32'd5;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 14; c++) begin
            bus.i_start = (c == 5);
            if (c == 5) begin
                bus.i_md_op = 2'b11; bus.i_operand_a = 32'd9; bus.i_operand_b = 32'd0;
            end
            bus.i_flush = (c == 10);
            @(posedge clk); #1;
            if (bus.o_done) done_seen++;
            if (c == 5) chk("ignored_start_busy", bus.o_busy, 1'b1);
            if (c == 10) chk("flush_to_idle", bus.o_busy, 1'b0);
        end
        bus.i_start = 1'b0; bus.i_flush = 1'b0;
        chk("flush_no_done", done_seen, 0);
        chk("flush_hi_kept", bus.o_hi, 32'h00000001);
        chk("flush_lo_kept", bus.o_lo, 32'h23456780);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_md_op = 2'b01;
        bus.i_operand_a = 32'd2; bus.i_operand_b = 32'd2;
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_flush = 1'b0;
        chk("start_with_flush_ignored", bus.o_busy, 1'b0);

        run_op("after_flush", 2'b01, 32'd3, 32'd5, hi, lo, dz);
        chk("after_flush_hi", hi, 32'd0);
        chk("after_flush_lo", lo, 32'd15);

        // MF stall across the whole busy window of DIVU 10/3.
        bus.i_mf_req = 1'b1;
        run_op("stall_divu", 2'b11, 32'd10, 32'd3, hi, lo, dz);
        chk("stall_divu_hi", hi, 32'd1);
        chk("stall_divu_lo", lo, 32'd3);

        // Mid-op reset clears everything the next cycle.
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_md_op = 2'b01;
        bus.i_operand_a = 32'hFFFFFFFF; bus.i_operand_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_busy", bus.o_busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midop_reset_flags", {bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_stall}, 4'b0000);
        chk("midop_reset_hi", bus.o_hi, 32'h0);
        chk("midop_reset_lo", bus.o_lo, 32'h0);
        rst_n = 1'b1;
        bus.i_mf_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_idle", bus.o_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
